// File: rtl/pixel_stream_source.sv
// Raster-order frame reader: pulls one image from a synchronous-read pixel memory and
// streams it with valid/ready, end-of-row/end-of-frame markers and busy/done status.
module pixel_stream_source #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28,
    parameter int unsigned ADDR_SIZE  = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 mem_en,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    input  logic                 ready_in,
    output logic                 data_valid,
    output logic [DATA_SIZE-1:0] pixel_out_data,
    output logic                 end_of_row,
    output logic                 end_of_frame,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {StIdle, StStream, StFinish} state_e;
    state_e state_q, state_d;

    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [ColW-1:0]      col_q, col_d;
    logic [RowW-1:0]      row_q, row_d;
    logic                 remain_q, remain_d;

    // Markers of the read in flight travel with it into the output/skid registers.
    logic                 fl_q, fl_eor_q, fl_eof_q;
    logic                 fl_d, fl_eor_d, fl_eof_d;

    logic                 out_valid_q, out_eor_q, out_eof_q;
    logic                 out_valid_d, out_eor_d, out_eof_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;
    logic                 skid_valid_q, skid_eor_q, skid_eof_q;
    logic                 skid_valid_d, skid_eor_d, skid_eof_d;
    logic [DATA_SIZE-1:0] skid_data_q, skid_data_d;

    logic       start_acc, xfer, last_col, last_addr;
    logic [1:0] pending, pending_after;

    assign xfer          = out_valid_q && ready_in;
    assign start_acc     = start && (state_q != StStream);
    assign last_col      = (col_q == ColW'(IMG_WIDTH - 1));
    assign last_addr     = last_col && (row_q == RowW'(IMG_HEIGHT - 1));
    assign pending       = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, fl_q};
    assign pending_after = pending - {1'b0, xfer};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StStream;
            StStream: if (xfer && out_eof_q) state_d = StFinish;
            StFinish: state_d = start ? StStream : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_en = (state_q == StStream) && remain_q && (pending_after < 2'd2);
        busy   = (state_q == StStream);
        done   = (state_q == StFinish);
    end

    always_comb begin
        addr_d   = addr_q;
        col_d    = col_q;
        row_d    = row_q;
        remain_d = remain_q;
        if (start_acc) begin
            addr_d   = '0;
            col_d    = '0;
            row_d    = '0;
            remain_d = 1'b1;
        end else if (mem_en) begin
            if (last_addr) begin
                remain_d = 1'b0;
            end else begin
                addr_d = addr_q + ADDR_SIZE'(1);
                if (last_col) begin
                    col_d = '0;
                    row_d = row_q + RowW'(1);
                end else begin
                    col_d = col_q + ColW'(1);
                end
            end
        end
    end

    always_comb begin
        fl_d         = mem_en;
        fl_eor_d     = last_col;
        fl_eof_d     = last_addr;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_eor_d    = out_eor_q;
        out_eof_d    = out_eof_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_eor_d   = skid_eor_q;
        skid_eof_d   = skid_eof_q;
        if (xfer) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_eor_d    = skid_eor_q;
                out_eof_d    = skid_eof_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        if (fl_q) begin
            if (!out_valid_d) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_rdata;
                out_eor_d   = fl_eor_q;
                out_eof_d   = fl_eof_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = mem_rdata;
                skid_eor_d   = fl_eor_q;
                skid_eof_d   = fl_eof_q;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            remain_q     <= 1'b0;
            fl_q         <= 1'b0;
            fl_eor_q     <= 1'b0;
            fl_eof_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_eor_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_eor_q   <= 1'b0;
            skid_eof_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            col_q        <= col_d;
            row_q        <= row_d;
            remain_q     <= remain_d;
            fl_q         <= fl_d;
            fl_eor_q     <= fl_eor_d;
            fl_eof_q     <= fl_eof_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_eor_q    <= out_eor_d;
            out_eof_q    <= out_eof_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_eor_q   <= skid_eor_d;
            skid_eof_q   <= skid_eof_d;
        end
    end

    assign mem_addr       = addr_q;
    assign data_valid     = out_valid_q;
    assign pixel_out_data = out_data_q;
    assign end_of_row     = out_eor_q;
    assign end_of_frame   = out_eof_q;

    // A capture must never find both the output and skid registers occupied.
    assert property (@(posedge clock) disable iff (reset)
        !(fl_q && out_valid_q && skid_valid_q && !xfer));

endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source on a 4x3 image with mem[i] = i.
module tb_pixel_stream_source;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned N  = W * H;
    localparam int unsigned AW = $clog2(N);

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          ready_in;
    logic          data_valid;
    logic [7:0]    pixel_out_data;
    logic          end_of_row;
    logic          end_of_frame;
    logic          busy;
    logic          done;

    pixel_stream_source #(
        .DATA_SIZE (8),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .ready_in      (ready_in),
        .data_valid    (data_valid),
        .pixel_out_data(pixel_out_data),
        .end_of_row    (end_of_row),
        .end_of_frame  (end_of_frame),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [N];
    initial for (int i = 0; i < int'(N); i++) mem[i] = 8'(i);
    always @(posedge clock) if (mem_en) mem_rdata <= mem[mem_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Transfer monitor: logs {eof, eor, data} per transfer, counts done pulses, checks holds.
    logic [9:0] xq[$];
    int         done_cnt   = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_pkt   = '0;
    always @(negedge clock) begin
        if (prev_stall && !reset)
            check_eq("stall_hold", {data_valid, end_of_frame, end_of_row, pixel_out_data},
                     {1'b1, prev_pkt});
        if (data_valid && ready_in) xq.push_back({end_of_frame, end_of_row, pixel_out_data});
        if (done) done_cnt++;
        prev_stall = data_valid && !ready_in && !reset;
        prev_pkt   = {end_of_frame, end_of_row, pixel_out_data};
    end

    int mode   = 0;   // 0: ready high, 1: stall window, 2: alternating
    bit seen   = 1'b0;
    int vcount = 0;

    task automatic tick();
        @(posedge clock);
        #1;
        if (data_valid && !seen) begin
            seen   = 1'b1;
            vcount = 0;
        end else if (seen) begin
            vcount++;
        end
        case (mode)
            1:       ready_in = !(seen && vcount >= 3 && vcount <= 6);
            2:       ready_in = !seen || (vcount % 2 == 1);
            default: ready_in = 1'b1;
        endcase
        #1;
        if (mode == 1 && seen && vcount >= 3 && vcount <= 6) begin
            check_eq("stall_mem_en", 32'(mem_en), 32'd0);
            check_eq("stall_pixel", {data_valid, pixel_out_data}, {1'b1, 8'd3});
        end
        if (mode == 2 && seen && vcount < 24)
            check_eq("alt_pixel", {data_valid, pixel_out_data}, {1'b1, 8'(vcount / 2)});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("frame_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic check_frames(input string tag, input int base, input int nframes);
        check_eq({tag, "_count"}, 32'(xq.size() - base), 32'(nframes * int'(N)));
        for (int i = 0; i < nframes * int'(N) && base + i < xq.size(); i++) begin
            int p = i % int'(N);
            logic [9:0] exp;
            exp = {(p == int'(N) - 1), (p % int'(W) == int'(W) - 1), 8'(p)};
            check_eq(tag, 32'(xq[base + i]), 32'(exp));
        end
    endtask

    initial begin
        int base, d0, n;
        reset    = 1'b1;
        start    = 1'b0;
        ready_in = 1'b1;
        #1;
        check_eq("reset_outs", {mem_en, 4'(mem_addr), data_valid, pixel_out_data,
                                end_of_row, end_of_frame, busy, done}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        tick();

        // Exact latency and order with ready held high.
        mode = 0; seen = 0; base = xq.size(); d0 = done_cnt;
        pulse_start();
        check_eq("lat_k", {mem_en, 4'(mem_addr), busy, data_valid}, {1'b1, 4'd0, 1'b1, 1'b0});
        tick();
        check_eq("lat_k1_valid", 32'(data_valid), 32'd0);
        for (int i = 0; i < int'(N); i++) begin
            tick();
            check_eq("stream_pixel", {data_valid, end_of_frame, end_of_row, pixel_out_data},
                     {1'b1, (i == int'(N) - 1), (i % int'(W) == int'(W) - 1), 8'(i)});
        end
        tick();
        check_eq("done_pulse", {done, busy, data_valid}, {1'b1, 1'b0, 1'b0});
        tick();
        check_eq("done_clear", {done, busy}, {1'b0, 1'b0});
        check_eq("hold_last_addr", 32'(mem_addr), 32'(N - 1));
        check_frames("basic", base, 1);

        // Stall window after the first valid.
        mode = 1; seen = 0; base = xq.size(); d0 = done_cnt;
        pulse_start();
        run_until_done(d0 + 1, 100);
        check_frames("stall", base, 1);

        // Alternating ready.
        mode = 2; seen = 0; base = xq.size(); d0 = done_cnt;
        pulse_start();
        run_until_done(d0 + 1, 100);
        check_frames("alt", base, 1);

        // Second start mid-frame is ignored.
        mode = 0; seen = 0; base = xq.size(); d0 = done_cnt;
        ready_in = 1'b1;
        pulse_start();
        n = 0;
        while (xq.size() - base < 6 && n < 50) begin tick(); n++; end
        pulse_start();
        check_eq("midstart_busy", 32'(busy), 32'd1);
        run_until_done(d0 + 1, 100);
        repeat (20) tick();
        check_eq("midstart_dones", 32'(done_cnt - d0), 32'd1);
        check_frames("midstart", base, 1);

        // Asynchronous reset mid-frame.
        seen = 0; base = xq.size(); d0 = done_cnt;
        pulse_start();
        n = 0;
        while (xq.size() - base < 7 && n < 50) begin tick(); n++; end
        #2 reset = 1'b1;
        #1;
        check_eq("areset_outs", {mem_en, 4'(mem_addr), data_valid, pixel_out_data,
                                 end_of_row, end_of_frame, busy, done}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        check_eq("pre_reset_count", 32'(xq.size() - base), 32'd7);
        base = xq.size();
        repeat (10) tick();
        check_eq("post_reset_quiet", {32'(xq.size() - base)}, 32'd0);
        check_eq("post_reset_idle", {data_valid, busy, done}, 3'b000);
        check_eq("post_reset_dones", 32'(done_cnt - d0), 32'd0);
        seen = 0; d0 = done_cnt;
        pulse_start();
        run_until_done(d0 + 1, 100);
        check_frames("fresh", base, 1);

        // Start during the done cycle: back-to-back frames.
        seen = 0; base = xq.size(); d0 = done_cnt;
        pulse_start();
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        check_eq("b2b_done_seen", 32'(done), 32'd1);
        pulse_start();
        check_eq("b2b_no_gap", {busy, done, mem_en, 4'(mem_addr)}, {1'b1, 1'b0, 1'b1, 4'd0});
        run_until_done(d0 + 2, 100);
        check_frames("b2b", base, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
